// File: rtl/line_fill_engine_pkg.sv
// Shared cache-line constants, fill FSM encoding and the store-over-fill merge helper.
package line_fill_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BEATS = 2'd2,
        ST_WRITE = 2'd3
    } fill_state_e;

    localparam int LINE_BITS      = 128;
    localparam int BEATS_PER_LINE = 4;
    localparam int WAYS           = 4;
    localparam int CNT_W          = 2;
    localparam int OFFSET_BITS    = 4;
    localparam int IDX_LSB        = 4;
    localparam int IDX_MSB        = 5;
    localparam int IDX_W          = IDX_MSB - IDX_LSB + 1;

    function automatic logic [LINE_BITS-1:0] merge_line(
        input logic [LINE_BITS-1:0] st_data,
        input logic [LINE_BITS-1:0] st_mask,
        input logic [LINE_BITS-1:0] fill_line
    );
        return (st_mask & st_data) | (~st_mask & fill_line);
    endfunction

endpackage

// File: rtl/line_fill_engine_beat_buffer.sv
// Four-slot beat assembly buffer; one slot written per accepted memory beat.
module fill_beat_buffer
    import line_fill_engine_pkg::*;
#(
    parameter int BEAT_W = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [CNT_W-1:0]                 wr_slot,
    input  logic [BEAT_W-1:0]                wr_data,
    output logic [BEATS_PER_LINE*BEAT_W-1:0] line_out
);

    logic [BEAT_W-1:0] slot_q [BEATS_PER_LINE];
    logic [BEAT_W-1:0] slot_d [BEATS_PER_LINE];

    always_comb begin
        slot_d = slot_q;
        if (wr_en) begin
            slot_d[wr_slot] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BEATS_PER_LINE; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            slot_q <= slot_d;
        end
    end

    always_comb begin
        line_out = '0;
        for (int i = 0; i < BEATS_PER_LINE; i++) begin
            line_out[i*BEAT_W +: BEAT_W] = slot_q[i];
        end
    end

endmodule

// File: rtl/line_fill_engine.sv
// Cache line fill: one memory read of four beats, store-byte merge, single full-line write.
module line_fill_engine
    import line_fill_engine_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int BEAT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [WAYS-1:0]      req_way,
    input  logic [LINE_BITS-1:0] req_st_data,
    input  logic [LINE_BITS-1:0] req_st_mask,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [ADDR_W-1:0]    mem_req_addr,
    input  logic                 mem_rsp_valid,
    output logic                 mem_rsp_ready,
    input  logic [BEAT_W-1:0]    mem_rsp_data,
    output logic                 fill_valid,
    output logic                 fill_w,
    output logic [IDX_W-1:0]     fill_index,
    output logic [WAYS-1:0]      fill_way,
    output logic [LINE_BITS-1:0] fill_data,
    output logic [LINE_BITS-1:0] fill_mask,
    output logic                 fill_done
);

    fill_state_e                 state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [ADDR_W-1:OFFSET_BITS] addr_q, addr_d;
    logic [WAYS-1:0]             way_q, way_d;
    logic [LINE_BITS-1:0]        st_data_q, st_data_d;
    logic [LINE_BITS-1:0]        st_mask_q, st_mask_d;
    logic                        wr_q, wr_d;
    logic                        beat_wr;
    logic [LINE_BITS-1:0]        buf_line;
    logic                        addr_offset_unused;

    assign addr_offset_unused = ^req_addr[OFFSET_BITS-1:0];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        way_d         = way_q;
        st_data_d     = st_data_q;
        st_mask_d     = st_mask_q;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        mem_rsp_ready = 1'b0;
        beat_wr       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d    = req_addr[ADDR_W-1:OFFSET_BITS];
                    way_d     = req_way;
                    st_data_d = req_st_data;
                    st_mask_d = req_st_mask;
                    cnt_d     = '0;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = ST_BEATS;
                end
            end
            ST_BEATS: begin
                mem_rsp_ready = 1'b1;
                if (mem_rsp_valid) begin
                    beat_wr = 1'b1;
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == CNT_W'(BEATS_PER_LINE - 1)) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The write strobe gets its own flop so it cannot glitch on a multi-bit state change.
    assign wr_d = (state_d == ST_WRITE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            way_q     <= '0;
            st_data_q <= '0;
            st_mask_q <= '0;
            wr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            way_q     <= way_d;
            st_data_q <= st_data_d;
            st_mask_q <= st_mask_d;
            wr_q      <= wr_d;
        end
    end

    fill_beat_buffer #(
        .BEAT_W (BEAT_W)
    ) u_beat_buffer (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (beat_wr),
        .wr_slot  (cnt_q),
        .wr_data  (mem_rsp_data),
        .line_out (buf_line)
    );

    assign mem_req_addr = {addr_q, {OFFSET_BITS{1'b0}}};
    assign fill_valid   = wr_q;
    assign fill_w       = wr_q;
    assign fill_done    = wr_q;
    assign fill_mask    = {LINE_BITS{wr_q}};
    assign fill_index   = addr_q[IDX_MSB:IDX_LSB];
    assign fill_way     = way_q;
    assign fill_data    = merge_line(st_data_q, st_mask_q, buf_line);

endmodule
